// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter with open-drain pull enables.
// Inputs are synchronized and glitch-filtered; done/err report the device ACK outcome.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 7800,
  parameter int unsigned TIMEOUT_CYCLES = 975000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_BITS, S_ACK, S_RELEASE_WAIT, S_DONE, S_FAIL
  } state_t;

  state_t            state, next;
  logic [1:0]        sync1, sync2, filt;
  logic              clk_prev, fall_edge;
  logic [INH_W-1:0]  inh_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [3:0]        bit_cnt;
  logic [9:0]        frame;
  logic              data_oe_q;
  logic              accept, timeout, counting;

  // Bit 0 carries ps2_clk, bit 1 carries ps2_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '1;
      sync2    <= '1;
      clk_prev <= 1'b1;
    end else begin
      sync1    <= {ps2_data_i, ps2_clk_i};
      sync2    <= sync1;
      clk_prev <= filt[0];
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_flt
    logic [FLT_W-1:0] fcnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        filt[g] <= 1'b1;
        fcnt    <= '0;
      end else if (sync2[g] == filt[g]) begin
        fcnt <= '0;
      end else if (fcnt == FLT_W'(FILTER_LEN - 1)) begin
        filt[g] <= sync2[g];
        fcnt    <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign fall_edge = clk_prev & ~filt[0];
  assign accept    = (state == S_IDLE) & tx_valid;
  assign counting  = (state == S_START) | (state == S_BITS) |
                     (state == S_ACK) | (state == S_RELEASE_WAIT);
  assign timeout   = counting & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  always_comb begin
    next        = state;
    tx_ready    = 1'b0;
    busy        = 1'b1;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      S_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) next = S_INHIBIT;
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) next = S_START;
      end
      S_START: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        next        = timeout ? S_FAIL : S_BITS;
      end
      S_BITS: begin
        ps2_data_oe = data_oe_q;
        if (timeout)                          next = S_FAIL;
        else if (fall_edge && bit_cnt == 4'd9) next = S_ACK;
      end
      S_ACK: begin
        if (timeout)        next = S_FAIL;
        else if (fall_edge) next = filt[1] ? S_FAIL : S_RELEASE_WAIT;
      end
      S_RELEASE_WAIT: begin
        if (timeout)             next = S_FAIL;
        else if (filt == 2'b11)  next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        next = S_IDLE;
      end
      S_FAIL: begin
        err  = 1'b1;
        next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  // Timeout counter is zeroed throughout INHIBIT so the START cycle counts as cycle 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame     <= '0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      bit_cnt   <= '0;
      data_oe_q <= 1'b0;
    end else begin
      if (accept) begin
        frame   <= {1'b1, ~^tx_data, tx_data};
        inh_cnt <= '0;
      end
      if (state == S_INHIBIT) begin
        inh_cnt <= inh_cnt + 1'b1;
        to_cnt  <= '0;
      end
      if (counting) to_cnt <= to_cnt + 1'b1;
      case (state)
        S_IDLE:  data_oe_q <= 1'b0;
        S_START: begin
          bit_cnt   <= '0;
          data_oe_q <= 1'b1;
        end
        S_BITS: begin
          if (fall_edge && !timeout) begin
            data_oe_q <= ~frame[bit_cnt];
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on an open-drain bus.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic       ps2_clk_i, ps2_data_i;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch_low = 1'b0;
  int         checks = 0, fails = 0, done_cnt = 0, err_cnt = 0;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low | glitch_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(3000), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .err(err)
  );

  always #100 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    chk1("ready_before_send", tx_ready, 1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic hi_phase(input bit g, input int t);
    if (g) begin
      #(t / 2);
      glitch_low = 1'b1;
      #150;
      glitch_low = 1'b0;
      #(t / 2 - 150);
    end else begin
      #(t);
    end
  endtask

  task automatic wait_bits();
    int n = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 300) begin
      n++;
      tick();
    end
    chk1("request_to_send_seen", n < 300, 1'b1);
  endtask

  // Device: start bit read at clock release, bits 1..10 read on rising edges, ACK on 11th low phase.
  task automatic dev_xact(input bit ack, input bit g, output logic [10:0] cap);
    wait_bits();
    cap[0] = ps2_data_i;
    hi_phase(g, 10000);
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      #20000;
      dev_clk_low = 1'b0;
      cap[k] = ps2_data_i;
      hi_phase(g, 20000);
    end
    dev_clk_low  = 1'b1;
    dev_data_low = ack;
    #20000;
    dev_clk_low = 1'b0;
    #5000;
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 600) begin
      n++;
      tick();
    end
    chk1(tag, done, 1'b1);
  endtask

  initial begin
    logic [10:0] cap;
    int n, d0, e0;

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_tx_ready", tx_ready, 1'b1);
    chk1("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk1("rst_data_oe", ps2_data_oe, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 0xF4: inhibit length, frame, done timing
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
      n++;
      tick();
    end
    chkn("inhibit_len", n, 20);
    chk1("start_clk_low", ps2_clk_oe, 1'b1);
    chk1("start_data_low", ps2_data_oe, 1'b1);
    dev_xact(1'b1, 1'b0, cap);
    chkn("frame_f4", int'(cap), 'h5E8);
    wait_done("done_f4");
    chk1("busy_at_done", busy, 1'b1);
    chk1("ready_at_done", tx_ready, 1'b0);
    tick();
    chk1("busy_after_done", busy, 1'b0);
    chk1("ready_after_done", tx_ready, 1'b1);
    chk1("done_one_cycle", done, 1'b0);
    tick();
    chkn("done_count_f4", done_cnt - d0, 1);
    chkn("err_count_f4", err_cnt - e0, 0);

    // 0xFF: parity 1
    d0 = done_cnt; e0 = err_cnt;
    send(8'hFF);
    dev_xact(1'b1, 1'b0, cap);
    chkn("frame_ff", int'(cap), 'h7FE);
    wait_done("done_ff");
    repeat (2) tick();
    chkn("done_count_ff", done_cnt - d0, 1);
    chkn("err_count_ff", err_cnt - e0, 0);

    // silent device: timeout
    send(8'h00);
    n = 0;
    while (!ps2_data_oe && n < 100) begin
      n++;
      tick();
    end
    chk1("timeout_start_seen", ps2_data_oe, 1'b1);
    n = 0;
    while (!err && n < 4000) begin
      n++;
      tick();
    end
    chkn("timeout_len", n, 3000);
    chk1("timeout_clk_oe", ps2_clk_oe, 1'b0);
    chk1("timeout_data_oe", ps2_data_oe, 1'b0);
    tick();
    chk1("timeout_err_one_cycle", err, 1'b0);
    chk1("timeout_ready", tx_ready, 1'b1);

    // NACK, then a normal transfer
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    dev_xact(1'b0, 1'b0, cap);
    repeat (20) tick();
    chkn("nack_err_count", err_cnt - e0, 1);
    chkn("nack_done_count", done_cnt - d0, 0);
    chk1("nack_idle", tx_ready, 1'b1);
    d0 = done_cnt;
    send(8'hF4);
    dev_xact(1'b1, 1'b0, cap);
    chkn("frame_after_nack", int'(cap), 'h5E8);
    wait_done("done_after_nack");
    repeat (2) tick();
    chkn("done_count_after_nack", done_cnt - d0, 1);

    // tx_valid while busy is ignored
    d0 = done_cnt;
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'h12;
    repeat (5) tick();
    chk1("busy_not_ready", tx_ready, 1'b0);
    tx_valid = 1'b0;
    dev_xact(1'b1, 1'b0, cap);
    chkn("frame_a5", int'(cap), 'h74A);
    wait_done("done_a5");
    repeat (5) tick();
    chk1("no_second_xact", busy, 1'b0);
    chkn("done_count_a5", done_cnt - d0, 1);

    // async reset during BITS
    send(8'h3C);
    wait_bits();
    dev_clk_low = 1'b1;
    #20000;
    dev_clk_low = 1'b0;
    #20000;
    dev_clk_low = 1'b1;
    #10000;
    chk1("bits_busy", busy, 1'b1);
    chk1("bits_data_oe", ps2_data_oe, 1'b1);
    d0 = done_cnt; e0 = err_cnt;
    rst = 1'b1;
    #1;
    chk1("arst_clk_oe", ps2_clk_oe, 1'b0);
    chk1("arst_data_oe", ps2_data_oe, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_ready", tx_ready, 1'b1);
    dev_clk_low = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (50) tick();
    chkn("arst_no_done", done_cnt - d0, 0);
    chkn("arst_no_err", err_cnt - e0, 0);
    chk1("arst_idle", tx_ready, 1'b1);

    // glitches on clock high phases
    d0 = done_cnt; e0 = err_cnt;
    send(8'h5A);
    dev_xact(1'b1, 1'b1, cap);
    chkn("frame_glitch", int'(cap), 'h6B4);
    wait_done("done_glitch");
    repeat (2) tick();
    chkn("done_count_glitch", done_cnt - d0, 1);
    chkn("err_count_glitch", err_cnt - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
